fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter that shares the write side of the async FIFO between NUM_REQ requesters.
- Lives entirely in the write clock domain. Drives the FIFO's write enable and write data directly, and gates every beat on the FIFO full flag.
- Grants in bursts of up to MAX_BURST beats per requester, then rotates to the next requester.

Parameters:
- NUM_REQ, 4: number of requesters. Must be at least 2; need not be a power of two.
- WIDTH, 4: data width. Must match the FIFO WIDTH.
- MAX_BURST, 4: maximum beats per grant tenure. Must be at least 1.
- CNT_WIDTH, 16: width of the stall counter (optional feature only).

Ports:
- clk_i, input, 1: write-domain clock; all state changes on its rising edge.
- reset_n_i, input, 1: asynchronous, active-low reset.
- req_i, input, NUM_REQ: per-requester write request; bit i belongs to requester i.
- data_i, input, NUM_REQ*WIDTH: packed write data; requester i uses slice [i*WIDTH +: WIDTH].
- full_i, input, 1: FIFO full flag, write domain.
- gnt_o, output, NUM_REQ: one-hot or zero; bit i high means requester i's beat transfers this cycle.
- wr_en_o, output, 1: FIFO write enable.
- wdata_o, output, WIDTH: FIFO write data.
- busy_o, output, 1: high while a burst owner is locked.
- stall_cnt_o, output, CNT_WIDTH: stall statistic. Present only with FIFO_ARB_STAT_EN.

Behaviour:
- Registered state:
  - state: IDLE or BURST
  - owner: clog2(NUM_REQ) bits
  - rr_ptr: clog2(NUM_REQ) bits
  - beat_cnt: clog2(MAX_BURST+1) bits
- Reset (async, reset_n_i=0):
  - state=IDLE, owner=0, rr_ptr=0, beat_cnt=0.
  - gnt_o, wr_en_o and busy_o forced 0; wdata_o=0.
  - All of this takes effect immediately, with no clock edge needed.
- Combinational outputs, zero latency:
  - wr_en_o = OR of gnt_o.
  - wdata_o = data slice of the granted requester; 0 when nothing is granted.
  - busy_o = (state==BURST).
- A beat transfers on the rising edge where gnt_o[i]=1. The FIFO samples it at that same edge.
- IDLE:
  - cand = first i with req_i[i]=1, scanning cyclically from rr_ptr (rr_ptr, rr_ptr+1, ..., wrapping from NUM_REQ-1 to 0).
  - gnt_o[cand] = 1 if any request is present and full_i=0.
  - On a transfer:
    - If MAX_BURST==1: stay IDLE, rr_ptr <= (cand+1) mod NUM_REQ.
    - Otherwise: go to BURST, owner <= cand, beat_cnt <= 1.
  - If full_i=1: no grant, state and rr_ptr unchanged, cand re-evaluated next cycle.
- BURST:
  - gnt_o[owner] = req_i[owner] & ~full_i; all other grant bits are 0.
  - On a transfer: beat_cnt <= beat_cnt+1. If beat_cnt+1 == MAX_BURST: go to IDLE, rr_ptr <= (owner+1) mod NUM_REQ, beat_cnt <= 0.
  - If req_i[owner]=0: no grant this cycle. Go to IDLE, rr_ptr <= (owner+1) mod NUM_REQ, beat_cnt <= 0 (early release).
  - If full_i=1 with req_i[owner]=1: stall. No grant, state/owner/beat_cnt held. Full never ends a burst.
- Requester contract:
  - A requester may drop req at any time.
  - Data only needs to be valid in cycles where its gnt_o bit is 1.
- Overflow guarantee: wr_en_o is never 1 while full_i=1.
- Fairness bound: each requester waits at most (NUM_REQ-1)*MAX_BURST transfers.

Optional Feature:
- Macro: FIFO_ARB_STAT_EN.
- Defined:
  - stall_cnt_o port exists.
  - Increments on every clock where full_i=1 and a grant would otherwise be issued: in IDLE with any req_i bit set, or in BURST with req_i[owner]=1.
  - Saturates at all-ones; async reset to 0.
- Undefined: port and counter logic are absent. Grant behaviour is identical either way.

Test Plan:
1. Reset: reset_n_i=0 with req_i=4'b1111, full_i=0 -> gnt_o=0, wr_en_o=0, busy_o=0. First cycle after release -> gnt_o=4'b0001, wr_en_o=1, wdata_o=data_i[3:0].
2. Rotation: req_i=4'b1111 held, full_i=0, MAX_BURST=4 -> owners 0,0,0,0,1,1,1,1,2,...,3, then back to 0. wr_en_o=1 every cycle; busy_o=1 from beat 2 onward; busy_o drops to 0 for exactly one cycle at each owner change, while the next owner's first beat is granted.
3. Early release: only req_i[1] set, dropped after 2 beats -> busy_o falls, rr_ptr=2. Then req_i=4'b0101 -> gnt_o=4'b0100, not 4'b0001.
4. Full stall: owner 2 at beat_cnt=2, full_i=1 for 3 cycles -> gnt_o=0, wr_en_o=0, owner held. full_i=0 -> two more beats from requester 2, then rotation. With FIFO_ARB_STAT_EN, stall_cnt_o=3.
5. Integration with async FIFO (DEPTH=16), read side idle: 4 requesters, 8 beats each -> exactly 16 writes, full_o=1, then no wr_en_o. Enabling reads drains the FIFO; all 32 words are read in grant order with no loss or duplication.
6. Mid-burst reset: reset_n_i=0 between clock edges at beat 2 of owner 1 -> outputs 0 immediately. After release: IDLE, requester 0 granted first.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one async-FIFO write port among NUM_REQ requesters.
// Optional stall statistic counter enabled by defining FIFO_ARB_STAT_EN.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ*WIDTH-1:0]   data_i,
  input  logic                       full_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic                       wr_en_o,
  output logic [WIDTH-1:0]           wdata_o,
  output logic                       busy_o
`ifdef FIFO_ARB_STAT_EN
  ,
  output logic [CNT_WIDTH-1:0]       stall_cnt_o
`endif
);

  localparam int unsigned IDX_W  = $clog2(NUM_REQ);
  localparam int unsigned BEAT_W = $clog2(MAX_BURST + 1);

  if (NUM_REQ < 2 || MAX_BURST < 1 || CNT_WIDTH < 1) begin : g_bad_param
    $error("fifo_wr_arbiter: illegal parameter combination");
  end

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   owner, owner_nxt;
  logic [IDX_W-1:0]   rr_ptr, rr_nxt;
  logic [BEAT_W-1:0]  beat_cnt, beat_nxt;
  logic [BEAT_W-1:0]  beat_inc;
  logic [NUM_REQ-1:0] gnt_c;
  logic [IDX_W-1:0]   cand, pidx;
  logic               found;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (32'(i) == NUM_REQ - 1) ? '0 : i + IDX_W'(1);
  endfunction

  // First requester at or after rr_ptr, wrapping cyclically
  always_comb begin
    found = 1'b0;
    cand  = '0;
    pidx  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pidx = IDX_W'((32'(rr_ptr) + k) % NUM_REQ);
      if (!found && req_i[pidx]) begin
        found = 1'b1;
        cand  = pidx;
      end
    end
  end

  assign beat_inc = beat_cnt + BEAT_W'(1);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      rr_ptr   <= rr_nxt;
      beat_cnt <= beat_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    rr_nxt    = rr_ptr;
    beat_nxt  = beat_cnt;
    gnt_c     = '0;
    unique case (state)
      IDLE: begin
        if (found && !full_i) begin
          gnt_c[cand] = 1'b1;
          if (MAX_BURST == 1) begin
            rr_nxt = next_idx(cand);
          end else begin
            state_nxt = BURST;
            owner_nxt = cand;
            beat_nxt  = BEAT_W'(1);
          end
        end
      end
      BURST: begin
        if (!req_i[owner]) begin
          // Owner released early: hand the pointer past it
          state_nxt = IDLE;
          rr_nxt    = next_idx(owner);
          beat_nxt  = '0;
        end else if (!full_i) begin
          gnt_c[owner] = 1'b1;
          if (beat_inc == BEAT_W'(MAX_BURST)) begin
            state_nxt = IDLE;
            rr_nxt    = next_idx(owner);
            beat_nxt  = '0;
          end else begin
            beat_nxt = beat_inc;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Reset masks the combinational outputs without waiting for a clock edge
  assign gnt_o   = reset_n_i ? gnt_c : '0;
  assign wr_en_o = |gnt_o;
  assign busy_o  = reset_n_i && (state == BURST);

  always_comb begin
    wdata_o = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_o[i]) wdata_o = data_i[i*WIDTH +: WIDTH];
    end
  end

`ifdef FIFO_ARB_STAT_EN
  logic stall_c;

  // Cycles where a grant was withheld only because the FIFO was full
  assign stall_c = full_i && (((state == IDLE) && (|req_i)) ||
                              ((state == BURST) && req_i[owner]));

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stall_cnt_o <= '0;
    end else if (stall_c && (stall_cnt_o != {CNT_WIDTH{1'b1}})) begin
      stall_cnt_o <= stall_cnt_o + CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed vector table, mid-burst reset, random model run, FIFO fill.
module tb_fifo_wr_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned W  = 4;
  localparam int unsigned MB = 4;

  logic              clk = 1'b0;
  logic              reset_n_i;
  logic [NR-1:0]     req_i;
  logic [NR*W-1:0]   data_i;
  logic              full_i;
  logic [NR-1:0]     gnt_o;
  logic              wr_en_o;
  logic [W-1:0]      wdata_o;
  logic              busy_o;
`ifdef FIFO_ARB_STAT_EN
  logic [15:0]       stall_cnt_o;
`endif

  fifo_wr_arbiter #(.NUM_REQ(NR), .WIDTH(W), .MAX_BURST(MB), .CNT_WIDTH(16)) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n_i),
    .req_i     (req_i),
    .data_i    (data_i),
    .full_i    (full_i),
    .gnt_o     (gnt_o),
    .wr_en_o   (wr_en_o),
    .wdata_o   (wdata_o),
    .busy_o    (busy_o)
`ifdef FIFO_ARB_STAT_EN
    ,
    .stall_cnt_o (stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic [NR-1:0] req;
    logic          full;
    logic [NR-1:0] gnt;
    logic          busy;
  } vec_t;

  typedef struct {
    logic [NR-1:0] gnt;
    logic          busy;
    logic [W-1:0]  wdata;
    string         name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  logic [W-1:0] fifo_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state
  bit m_burst;
  int m_owner, m_ptr, m_beat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic [3:0] req, input logic full,
                              input logic [3:0] gnt, input logic busy);
    vec_t v;
    v.rst = rst; v.req = req; v.full = full; v.gnt = gnt; v.busy = busy;
    return v;
  endfunction

  task automatic model_reset();
    m_burst = 0; m_owner = 0; m_ptr = 0; m_beat = 0;
  endtask

  task automatic model_step(input logic [NR-1:0] req, input logic full,
                            output logic [NR-1:0] g, output logic busy);
    int cand;
    g = '0;
    busy = m_burst;
    cand = -1;
    if (!m_burst) begin
      for (int k = 0; k < int'(NR); k++)
        if (cand < 0 && req[(m_ptr + k) % NR]) cand = (m_ptr + k) % NR;
      if (cand >= 0 && !full) begin
        g[cand] = 1'b1;
        m_burst = 1; m_owner = cand; m_beat = 1;
      end
    end else if (!req[m_owner]) begin
      m_burst = 0; m_ptr = (m_owner + 1) % NR; m_beat = 0;
    end else if (!full) begin
      g[m_owner] = 1'b1;
      m_beat++;
      if (m_beat == int'(MB)) begin
        m_burst = 0; m_ptr = (m_owner + 1) % NR; m_beat = 0;
      end
    end
  endtask

  // Drive one cycle, queue its expectation, then sample mid-cycle and compare
  task automatic cycle(input logic rst, input logic [NR-1:0] req, input logic full,
                       input logic [NR-1:0] egnt, input logic ebusy, input string name);
    exp_t e, a;
    reset_n_i = rst;
    req_i     = req;
    full_i    = full;
    data_i    = 16'($urandom);
    e.gnt = egnt; e.busy = ebusy; e.wdata = '0; e.name = name;
    for (int i = 0; i < int'(NR); i++) if (egnt[i]) e.wdata = data_i[i*W +: W];
    sb.push_back(e);
    #4;
    a = sb.pop_front();
    chk({a.name, "_gnt"},   32'(gnt_o),   32'(a.gnt));
    chk({a.name, "_wr_en"}, 32'(wr_en_o), 32'(|a.gnt));
    chk({a.name, "_wdata"}, 32'(wdata_o), 32'(a.wdata));
    chk({a.name, "_busy"},  32'(busy_o),  32'(a.busy));
    @(posedge clk); #1;
  endtask

  task automatic hard_reset();
    reset_n_i = 1'b0; req_i = '0; full_i = 1'b0; data_i = '0;
    #2;
    reset_n_i = 1'b1;
    model_reset();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [NR-1:0] rq, eg;
    logic          fl, eb;
    int            count;
    int            sent[NR];

    reset_n_i = 1'b0; req_i = '0; full_i = 1'b0; data_i = '0;
    @(posedge clk); #1;

    // Reset then full rotation
    vecs.push_back(mk(0, 4'b1111, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b1111, 0, 4'b0000, 0));
    for (int o = 0; o < 4; o++) begin
      vecs.push_back(mk(1, 4'b1111, 0, 4'(1 << o), 0));
      for (int b = 1; b < int'(MB); b++) vecs.push_back(mk(1, 4'b1111, 0, 4'(1 << o), 1));
    end
    vecs.push_back(mk(1, 4'b1111, 0, 4'b0001, 0));
    // Early release: requester 0 drops, then requester 1 for two beats
    vecs.push_back(mk(1, 4'b0010, 0, 4'b0000, 1));
    vecs.push_back(mk(1, 4'b0010, 0, 4'b0010, 0));
    vecs.push_back(mk(1, 4'b0010, 0, 4'b0010, 1));
    vecs.push_back(mk(1, 4'b0000, 0, 4'b0000, 1));
    vecs.push_back(mk(1, 4'b0101, 0, 4'b0100, 0));
    // Full stall at beat 2 of owner 2
    vecs.push_back(mk(1, 4'b0101, 0, 4'b0100, 1));
    for (int s = 0; s < 3; s++) vecs.push_back(mk(1, 4'b0101, 1, 4'b0000, 1));
    vecs.push_back(mk(1, 4'b0101, 0, 4'b0100, 1));
    vecs.push_back(mk(1, 4'b0101, 0, 4'b0100, 1));
    vecs.push_back(mk(1, 4'b0101, 0, 4'b0001, 0));
    // Full while idle, then single requester 3
    vecs.push_back(mk(1, 4'b0000, 0, 4'b0000, 1));
    vecs.push_back(mk(1, 4'b1000, 1, 4'b0000, 0));
    vecs.push_back(mk(1, 4'b1000, 0, 4'b1000, 0));
    vecs.push_back(mk(1, 4'b0000, 0, 4'b0000, 1));

    for (int i = 0; i < vecs.size(); i++)
      cycle(vecs[i].rst, vecs[i].req, vecs[i].full, vecs[i].gnt, vecs[i].busy,
            $sformatf("vec%0d", i));

    // Mid-burst asynchronous reset at beat 2 of owner 1
    cycle(1, 4'b0010, 0, 4'b0010, 0, "mid_b1");
    cycle(1, 4'b0010, 0, 4'b0010, 1, "mid_b2");
    reset_n_i = 1'b0;
    #1;
    chk("mid_rst_gnt",   32'(gnt_o),   32'd0);
    chk("mid_rst_wr_en", 32'(wr_en_o), 32'd0);
    chk("mid_rst_busy",  32'(busy_o),  32'd0);
    chk("mid_rst_wdata", 32'(wdata_o), 32'd0);
    #1;
    reset_n_i = 1'b1;
    req_i = 4'b1111;
    #1;
    chk("post_rst_gnt",  32'(gnt_o),  32'b0001);
    chk("post_rst_busy", 32'(busy_o), 32'd0);
    @(posedge clk); #1;

    // Random traffic against the reference model
    hard_reset();
    for (int c = 0; c < 300; c++) begin
      rq = 4'($urandom);
      fl = ($urandom_range(0, 3) == 0);
      model_step(rq, fl, eg, eb);
      cycle(1, rq, fl, eg, eb, "rand");
    end

    // Fill a 16-deep FIFO model with all requesters active
    hard_reset();
    count = 0;
    for (int i = 0; i < int'(NR); i++) sent[i] = 0;
    for (int c = 0; c < 40; c++) begin
      req_i  = 4'b1111;
      full_i = (count >= 16);
      for (int i = 0; i < int'(NR); i++) data_i[i*W +: W] = 4'(i * 4 + sent[i]);
      #4;
      chk("no_wr_when_full", 32'(wr_en_o & full_i), 32'd0);
      if (wr_en_o) begin
        fifo_q.push_back(wdata_o);
        count++;
        for (int i = 0; i < int'(NR); i++) if (gnt_o[i]) sent[i]++;
      end
      @(posedge clk); #1;
    end
    chk("fill_count", 32'(count), 32'd16);
    chk("fill_qsize", 32'(fifo_q.size()), 32'd16);
    for (int k = 0; k < 16 && fifo_q.size() > 0; k++)
      chk($sformatf("fill_word%0d", k), 32'(fifo_q.pop_front()), 32'(k));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
